l1_dense_engine: RTL and testbench

Sequential dense-layer compute stage that sits directly downstream of the weight/bias memory controller. On `start` it drives `layer_sel`/`row_idx` to step through all input rows, reads one input activation per row from the input buffer, and performs `N_OUT` parallel signed MACs per cycle against the packed weight bus. It then adds nothing further (bias is preloaded), applies ReLU, shift-requantises to int8 and presents the hidden-layer vector to layer 2 with a `done` pulse.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/l1_dense_engine_mac_lane.sv | 71 +++++++
 rtl/l1_dense_engine.sv | 110 +++++++++++
 tb/tb_l1_dense_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer engines and the weight/bias memory
// controller: default geometry, FSM state encoding and layer-select codes.
package nn_pkg;

  localparam int N_IN_DEFAULT  = 784;
  localparam int N_OUT_DEFAULT = 32;
  localparam int ACC_W_DEFAULT = 32;
  localparam int SHIFT_DEFAULT = 7;

  localparam logic [1:0] LAYER_IDLE = 2'd0;
  localparam logic [1:0] LAYER_L1   = 2'd1;
  localparam logic [1:0] LAYER_L2   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_MAC  = 3'd2,
    ST_ACT  = 3'd3,
    ST_DONE = 3'd4
  } l1_state_e;

endpackage

// File: rtl/l1_dense_engine_mac_lane.sv
// One neuron of the layer-1 engine: bias load, signed 8x8 MAC into a wide
// accumulator, and a captured output pair (raw accumulator + int8 requantised).
// Optional macro L1_DENSE_RELU_EN clamps negative accumulators to zero before
// the requantising shift.
module mac_lane
  import nn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_bias_i,
  input  logic                    acc_en_i,
  input  logic                    capture_i,
  input  logic signed [7:0]       b_i,
  input  logic signed [7:0]       w_i,
  input  logic signed [7:0]       x_i,
  output logic [ACC_W-1:0]        acc_o,
  output logic [7:0]              act_o
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]        acc_out_q;
  logic [7:0]              act_out_q;
  logic signed [15:0]      prod;

  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] s;
    v = a;
`ifdef L1_DENSE_RELU_EN
    if (a[ACC_W-1]) v = '0;
`endif
    s = v >>> SHIFT;
    if (s > SAT_HI)      return 8'h7f;
    else if (s < SAT_LO) return 8'h80;
    else                 return s[7:0];
  endfunction

  assign prod = w_i * x_i;

  // Accumulator next-state: bias load has priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (load_bias_i)   acc_d = {{(ACC_W-8){b_i[7]}}, b_i};
    else if (acc_en_i) acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
  end

  // Accumulator and output registers; outputs only change on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      acc_out_q <= '0;
      act_out_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (capture_i) begin
        acc_out_q <= acc_q;
        act_out_q <= requant(acc_q);
      end
    end
  end

  assign acc_o = acc_out_q;
  assign act_o = act_out_q;

endmodule

// File: rtl/l1_dense_engine.sv
// Layer-1 dense engine: steps the weight memory through N_IN rows, runs N_OUT
// parallel MAC lanes, then requantises and pulses done.
// Optional macro L1_DENSE_RELU_EN (see mac_lane) applies ReLU before requant.
//
// state | meaning
// IDLE  | waiting for start, memory interface parked at layer 0 row 0
// BIAS  | row 0 presented, accumulators loaded with biases
// MAC   | one row per cycle accumulated into every lane
// ACT   | accumulators captured into output registers
// DONE  | one-cycle done pulse
module l1_dense_engine
  import nn_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int N_OUT = N_OUT_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             layer_sel,
  output logic [9:0]             row_idx,
  input  logic [N_OUT*8-1:0]     w_in_packed,
  input  logic [N_OUT*8-1:0]     b_in_packed,
  output logic [9:0]             x_addr,
  input  logic [7:0]             x_in,
  output logic [N_OUT*ACC_W-1:0] acc_out_packed,
  output logic [N_OUT*8-1:0]     act_out_packed
);

  localparam logic [9:0] LAST_ROW = 10'(N_IN - 1);

  l1_state_e  state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       load_bias, acc_en, capture;

  // State and row counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, lane controls and memory-interface outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_bias = 1'b0;
    acc_en    = 1'b0;
    capture   = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    layer_sel = LAYER_IDLE;
    row_idx   = '0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BIAS;
      ST_BIAS: begin
        layer_sel = LAYER_L1;
        load_bias = 1'b1;
        cnt_d     = '0;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        layer_sel = LAYER_L1;
        row_idx   = cnt_q;
        acc_en    = 1'b1;
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = ST_ACT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_ACT: begin
        capture = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign x_addr = row_idx;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    mac_lane #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load_bias_i (load_bias),
      .acc_en_i    (acc_en),
      .capture_i   (capture),
      .b_i         (b_in_packed[k*8 +: 8]),
      .w_i         (w_in_packed[k*8 +: 8]),
      .x_i         (x_in),
      .acc_o       (acc_out_packed[k*ACC_W +: ACC_W]),
      .act_o       (act_out_packed[k*8 +: 8])
    );
  end

endmodule

// File: tb/tb_l1_dense_engine.sv
// Self-checking bench for l1_dense_engine: combinational weight/bias/input
// memory model, reference accumulation model and a scoreboard of expected
// output vectors popped on each done pulse. Honours L1_DENSE_RELU_EN.
module tb_l1_dense_engine;

  localparam int N_IN  = 784;
  localparam int N_OUT = 32;
  localparam int ACC_W = 32;
  localparam int SHIFT = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   busy, done;
  logic [1:0]             layer_sel;
  logic [9:0]             row_idx, x_addr;
  logic [N_OUT*8-1:0]     w_in_packed, b_in_packed;
  logic [7:0]             x_in;
  logic [N_OUT*ACC_W-1:0] acc_out_packed;
  logic [N_OUT*8-1:0]     act_out_packed;

  int mode;
  int wconst, xconst;
  logic signed [7:0] bias_arr [N_OUT];

  int tests = 0;
  int fails = 0;

  logic [N_OUT*ACC_W-1:0] exp_acc_q [$];
  logic [N_OUT*8-1:0]     exp_act_q [$];

  always #5 clk = ~clk;

  l1_dense_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .layer_sel      (layer_sel),
    .row_idx        (row_idx),
    .w_in_packed    (w_in_packed),
    .b_in_packed    (b_in_packed),
    .x_addr         (x_addr),
    .x_in           (x_in),
    .acc_out_packed (acc_out_packed),
    .act_out_packed (act_out_packed)
  );

  function automatic int w_of(input int md, input int wc, input int k, input int r);
    if (md == 0) return wc;
    return ((k * 37 + r * 11 + 5) % 256) - 128;
  endfunction

  function automatic int x_of(input int md, input int xc, input int r);
    if (md == 0) return xc;
    return ((r * 13 + 7) % 256) - 128;
  endfunction

  function automatic logic [7:0] ref_act(input longint a);
    longint v;
    v = a;
`ifdef L1_DENSE_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> SHIFT;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // Memory controller / input buffer model, combinational on the addresses.
  always_comb begin
    w_in_packed = '0;
    b_in_packed = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_in_packed[k*8 +: 8] = 8'(w_of(mode, wconst, k, int'(row_idx)));
      b_in_packed[k*8 +: 8] = bias_arr[k];
    end
    x_in = 8'(x_of(mode, xconst, int'(x_addr)));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(output logic [N_OUT*ACC_W-1:0] ea, output logic [N_OUT*8-1:0] et);
    longint a;
    ea = '0;
    et = '0;
    for (int k = 0; k < N_OUT; k++) begin
      a = longint'(bias_arr[k]);
      for (int r = 0; r < N_IN; r++)
        a += longint'(w_of(mode, wconst, k, r)) * longint'(x_of(mode, xconst, r));
      ea[k*ACC_W +: ACC_W] = ACC_W'(a);
      et[k*8 +: 8]         = ref_act(a);
    end
  endtask

  task automatic set_cfg(input int md, input int wc, input int xc, input bit ramp_bias);
    mode   = md;
    wconst = wc;
    xconst = xc;
    for (int k = 0; k < N_OUT; k++)
      bias_arr[k] = ramp_bias ? 8'(k - 16) : 8'sd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_layer"}, 64'(layer_sel), 64'd0);
    check({tag, "_row"}, 64'(row_idx), 64'd0);
    check({tag, "_acc_out"}, 64'(acc_out_packed == '0), 64'd1);
    check({tag, "_act_out"}, 64'(act_out_packed == '0), 64'd1);
  endtask

  // restart_row >= 0: pulse start when that row is presented.
  // rst_row >= 0: assert reset when that row is presented and abort.
  // zero_chk: outputs must still read zero mid-run.
  task automatic run_inf(input string tag, input int restart_row, input int rst_row, input bit zero_chk);
    int cyc;
    bit got_done;
    logic [N_OUT*ACC_W-1:0] ea;
    logic [N_OUT*8-1:0]     et;
    if (rst_row < 0) begin
      predict(ea, et);
      exp_acc_q.push_back(ea);
      exp_act_q.push_back(et);
    end
    start    = 1'b1;
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < N_IN + 50) begin
      @(posedge clk); #1;
      cyc++;
      start = (restart_row >= 0 && layer_sel == 2'd1 && row_idx == 10'(restart_row));
      if (cyc == 1) begin
        check({tag, "_bias_busy"}, 64'(busy), 64'd1);
        check({tag, "_bias_layer"}, 64'(layer_sel), 64'd1);
        check({tag, "_bias_row"}, 64'(row_idx), 64'd0);
      end
      if (cyc == 50) begin
        check({tag, "_mac_row"}, 64'(row_idx), 64'd48);
        check({tag, "_x_addr"}, 64'(x_addr), 64'd48);
      end
      if (cyc == N_IN + 1) check({tag, "_last_row"}, 64'(row_idx), 64'(N_IN - 1));
      if (cyc == N_IN + 2) begin
        check({tag, "_act_layer"}, 64'(layer_sel), 64'd0);
        check({tag, "_act_busy"}, 64'(busy), 64'd1);
      end
      if (zero_chk && cyc == 400) begin
        check({tag, "_mid_acc_zero"}, 64'(acc_out_packed == '0), 64'd1);
        check({tag, "_mid_act_zero"}, 64'(act_out_packed == '0), 64'd1);
      end
      if (rst_row >= 0 && layer_sel == 2'd1 && row_idx == 10'(rst_row)) begin
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values({tag, "_abort"});
        return;
      end
      if (done) begin
        got_done = 1'b1;
        check({tag, "_latency"}, 64'(cyc), 64'(N_IN + 3));
        if (exp_acc_q.size() == 0) begin
          check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
          ea = exp_acc_q.pop_front();
          et = exp_act_q.pop_front();
          for (int k = 0; k < N_OUT; k++) begin
            check($sformatf("%s_acc%0d", tag, k), 64'(acc_out_packed[k*ACC_W +: ACC_W]), 64'(ea[k*ACC_W +: ACC_W]));
            check($sformatf("%s_act%0d", tag, k), 64'(act_out_packed[k*8 +: 8]), 64'(et[k*8 +: 8]));
          end
        end
      end
    end
    if (!got_done) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    // start held through the done cycle must not be accepted
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_no_accept_in_done"}, 64'(busy), 64'd0);
    check({tag, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    rst   = 1'b1;
    start = 1'b0;
    set_cfg(0, 1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);

    // all ones: 784 per neuron, 784>>>7 = 6
    set_cfg(0, 1, 1, 1'b0);
    run_inf("ones", -1, -1, 1'b0);
    check("ones_acc5_const", 64'(acc_out_packed[5*ACC_W +: ACC_W]), 64'(32'd784));
    check("ones_act5_const", 64'(act_out_packed[5*8 +: 8]), 64'(8'd6));

    // start re-pulsed at row 100 is ignored
    run_inf("restart", 100, -1, 1'b0);

    // all -1 weights
    set_cfg(0, -1, 1, 1'b0);
    run_inf("neg", -1, -1, 1'b0);
`ifdef L1_DENSE_RELU_EN
    check("neg_act0_const", 64'(act_out_packed[7:0]), 64'(8'd0));
`else
    check("neg_act0_const", 64'(act_out_packed[7:0]), 64'(8'hf9));
`endif

    // positive saturation
    set_cfg(0, 127, 127, 1'b0);
    run_inf("satpos", -1, -1, 1'b0);
    check("satpos_acc0_const", 64'(acc_out_packed[ACC_W-1:0]), 64'(32'd12645136));
    check("satpos_act0_const", 64'(act_out_packed[7:0]), 64'(8'd127));

    // negative saturation
    set_cfg(0, -128, 127, 1'b0);
    run_inf("satneg", -1, -1, 1'b0);

    // bias only, ramp k-16
    set_cfg(0, 0, 1, 1'b1);
    run_inf("bias", -1, -1, 1'b0);

    // per-lane, per-row varying pattern
    set_cfg(1, 0, 0, 1'b1);
    run_inf("pattern", -1, -1, 1'b0);

    // abort at row 400, then confirm no stray done
    set_cfg(0, 1, 1, 1'b0);
    run_inf("abort", -1, 400, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < N_IN + 10; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // fresh run after abort: outputs zero until done, then ones result
    run_inf("after_abort", -1, -1, 1'b1);
    check("sb_drained", 64'(exp_acc_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
